vga_timing_detector: RTL and testbench
======================================

// Module: vga_timing_detector
// PURPOSE
//  Receive-side counterpart of the VGA Counter. Takes one line/frame timing stream (Sync_in,
//  Active_in) on the pixel clock and recovers its total period, active length, sync width and
//  the current position. Locks once the timing repeats. Used for self-check of the timing
//  generator and for mode detection on incoming timing.
// PARAMETERS
//  REZ_WIDTH      11  width of active-length and sync-width results
//  REZ_MAX_WIDTH  12  width of period counter, Meas_max and Position
//  LOCK_COUNT     3   consecutive identical periods needed to assert Locked (>=2)
// PORTS
//  Clk              in   1              pixel clock, all logic on rising edge
//  Rst_n            in   1              asynchronous, active-low reset
//  Sync_in          in   1              sync pulse, active-high, synchronous to Clk
//  Active_in        in   1              active-video flag, synchronous to Clk
//  Meas_max         out  REZ_MAX_WIDTH  last measured period in cycles (e.g. 800)
//  Meas_activ       out  REZ_WIDTH      Active_in-high cycles in last period (e.g. 640)
//  Meas_sync_width  out  REZ_WIDTH      Sync_in-high cycles in last period
//  Meas_valid       out  1              1-cycle pulse, Meas_* updated this cycle
//  Position         out  REZ_MAX_WIDTH  0-based cycle index within period; 0 when not Locked
//  Locked           out  1              timing stable
//  Err              out  1              1-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, all counters 0. Rst_n low mid-operation clears at once.
//  - Edge: sync_d registers Sync_in. edge = Sync_in & ~sync_d, evaluated in the current cycle.
//  - Counters, on an edge cycle: period_cnt<=1, active_cnt<=Active_in, sync_cnt<=1.
//    Otherwise: period_cnt+1; active_cnt+Active_in; sync_cnt+Sync_in.
//    active_cnt and sync_cnt saturate at 2^REZ_WIDTH-1.
//  - Capture, on an edge cycle in MEASURE or LOCKED: Meas_max<=period_cnt,
//    Meas_activ<=active_cnt, Meas_sync_width<=sync_cnt, Meas_valid<=1.
//    Outputs are visible on the cycle after the edge.
//    Example: edges at t and t+800 give Meas_max=800.
//  - Position = period_cnt-1 while Locked. It is 0 on the cycle after the edge and P-1 on the
//    next edge cycle.
//  - FSM:
//    IDLE: first edge -> MEASURE. No capture, because no full period has been seen.
//    MEASURE: on each capture, compare (period, active) with the previous capture.
//      Equal: match_cnt+1. Unequal: match_cnt<=1.
//      match_cnt reaching LOCK_COUNT -> LOCKED, Locked<=1 in the same cycle as Meas_valid.
//      The first capture sets match_cnt=1.
//    LOCKED: a capture with a different period or active value -> MEASURE, Locked<=0,
//      match_cnt<=1. Sync width is reported but does not affect lock.
//  - Timeout: no edge and period_cnt==2^REZ_MAX_WIDTH-1.
//    Response: Err pulse, state IDLE, Locked<=0, Meas_*<=0, counters cleared.
//    If an edge coincides with timeout, the edge wins and the capture is normal.
//  - A Sync_in held high gives no further edges and ends in timeout.
//  - Meas_valid and Err are never high in the same cycle.
// TESTING
//  1 Reset, then 5 lines with period 800, active 640, sync 96
//    -> Meas_valid at edges 2..5; Meas_max=800, Meas_activ=640, Meas_sync_width=96;
//       Locked rises with the capture at edge 4.
//  2 Locked at 800/640, then switch to 1184/1024
//    -> Locked falls at the first 1184 capture and re-rises on the 3rd identical capture.
//  3 Locked, then Sync_in stays low -> Err single pulse after 4095 cycles without an edge;
//    Locked=0, Meas_*=0; next edge re-enters MEASURE with no capture.
//  4 Locked at 800 -> Position=0 the cycle after the edge, 799 on the edge cycle,
//    monotonic in between.
//  5 Rst_n low mid-line while Locked -> all outputs 0 immediately;
//    after release, relock needs 1+LOCK_COUNT edges.
//  6 Period 3000, Active_in held high -> Meas_max=3000, Meas_activ=2047 (saturated).

Source files
------------

// File: rtl/vga_timing_detector.sv
// vga_timing_detector: recovers line/frame timing (period, active length,
// sync width, position) from a Sync_in/Active_in stream and locks once the
// measured period and active length repeat LOCK_COUNT times in a row.
//
// Output protocol: Meas_valid is a one-cycle, valid-only pulse. There is no
// ready input, so a consumer must sample Meas_* in the cycle Meas_valid is
// high. Meas_* then hold their values until the next capture, a timeout or a
// reset. Err is a one-cycle pulse and is never high together with Meas_valid.
module vga_timing_detector #(
    parameter int REZ_WIDTH     = 11,
    parameter int REZ_MAX_WIDTH = 12,
    parameter int LOCK_COUNT    = 3
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Sync_in,
    input  logic                     Active_in,
    output logic [REZ_MAX_WIDTH-1:0] Meas_max,
    output logic [REZ_WIDTH-1:0]     Meas_activ,
    output logic [REZ_WIDTH-1:0]     Meas_sync_width,
    output logic                     Meas_valid,
    output logic [REZ_MAX_WIDTH-1:0] Position,
    output logic                     Locked,
    output logic                     Err,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0]       LOCK_TGT   = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0]       MATCH_ONE  = MATCH_W'(1);
    localparam logic [REZ_MAX_WIDTH-1:0] PERIOD_TOP = '1;
    localparam logic [REZ_WIDTH-1:0]     RES_SAT    = '1;

    state_t                   state;
    state_t                   state_next;
    logic [MATCH_W-1:0]       match_cnt;
    logic [MATCH_W-1:0]       match_next;
    logic                     locked_next;

    logic                     sync_d;
    logic                     sync_edge;
    logic                     timeout;
    logic                     capture;
    logic                     same_timing;

    logic [REZ_MAX_WIDTH-1:0] period_cnt;
    logic [REZ_WIDTH-1:0]     active_cnt;
    logic [REZ_WIDTH-1:0]     sync_cnt;

    // An edge always wins over a timeout, so the two are mutually exclusive.
    assign sync_edge   = Sync_in & ~sync_d;
    assign timeout     = ~sync_edge && (period_cnt == PERIOD_TOP);
    assign capture     = sync_edge && (state != IDLE);
    assign same_timing = (period_cnt == Meas_max) && (active_cnt == Meas_activ);

    assign Position  = Locked ? (period_cnt - 1'b1) : '0;
    assign dbg_state = state;

    // Delay Sync_in by one cycle for rising-edge detection.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_d <= 1'b0;
        end else begin
            sync_d <= Sync_in;
        end
    end

    // Period, active and sync counters; the edge cycle itself counts as cycle 1.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            period_cnt <= '0;
            active_cnt <= '0;
            sync_cnt   <= '0;
        end else if (timeout) begin
            period_cnt <= '0;
            active_cnt <= '0;
            sync_cnt   <= '0;
        end else if (sync_edge) begin
            period_cnt <= REZ_MAX_WIDTH'(1);
            active_cnt <= {{(REZ_WIDTH-1){1'b0}}, Active_in};
            sync_cnt   <= REZ_WIDTH'(1);
        end else begin
            period_cnt <= period_cnt + 1'b1;
            if (Active_in && (active_cnt != RES_SAT)) begin
                active_cnt <= active_cnt + 1'b1;
            end
            if (Sync_in && (sync_cnt != RES_SAT)) begin
                sync_cnt <= sync_cnt + 1'b1;
            end
        end
    end

    // Result registers: latch the finished period on each capture, clear on timeout.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Meas_max        <= '0;
            Meas_activ      <= '0;
            Meas_sync_width <= '0;
            Meas_valid      <= 1'b0;
            Err             <= 1'b0;
        end else begin
            Meas_valid <= 1'b0;
            Err        <= timeout;
            if (timeout) begin
                Meas_max        <= '0;
                Meas_activ      <= '0;
                Meas_sync_width <= '0;
            end else if (capture) begin
                Meas_max        <= period_cnt;
                Meas_activ      <= active_cnt;
                Meas_sync_width <= sync_cnt;
                Meas_valid      <= 1'b1;
            end
        end
    end

    // FSM state register together with the match counter and lock flag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            match_cnt <= '0;
            Locked    <= 1'b0;
        end else begin
            state     <= state_next;
            match_cnt <= match_next;
            Locked    <= locked_next;
        end
    end

    // Next-state logic: count repeated captures, lock after LOCK_COUNT equal ones.
    always_comb begin
        state_next  = state;
        match_next  = match_cnt;
        locked_next = Locked;
        if (timeout) begin
            state_next  = IDLE;
            match_next  = '0;
            locked_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // First edge only starts a period; nothing to capture yet.
                    if (sync_edge) begin
                        state_next = MEASURE;
                        match_next = '0;
                    end
                end
                MEASURE: begin
                    if (capture) begin
                        if ((match_cnt == '0) || !same_timing) begin
                            match_next = MATCH_ONE;
                        end else begin
                            match_next = match_cnt + 1'b1;
                            if ((match_cnt + 1'b1) == LOCK_TGT) begin
                                state_next  = LOCKED;
                                locked_next = 1'b1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    // Sync width changes are reported but do not break lock.
                    if (capture && !same_timing) begin
                        state_next  = MEASURE;
                        match_next  = MATCH_ONE;
                        locked_next = 1'b0;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    match_next  = '0;
                    locked_next = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_detector.sv
// Bench for vga_timing_detector: a table of timing lines with the capture
// expected at each line's leading edge, a scoreboard queue for Meas_* values,
// and hand-written sequences for timeout, position and mid-line reset.
module tb_vga_timing_detector;

  localparam int RW  = 11;
  localparam int RMW = 12;
  localparam int LC  = 3;
  localparam int EW  = RMW + RW + RW + 1;
  localparam int NROWS = 24;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sync_in = 1'b0;
  logic           active_in = 1'b0;
  logic [RMW-1:0] meas_max;
  logic [RW-1:0]  meas_activ;
  logic [RW-1:0]  meas_sync_width;
  logic           meas_valid;
  logic [RMW-1:0] position;
  logic           locked;
  logic           err;
  logic [1:0]     dbg_state;

  vga_timing_detector #(
    .REZ_WIDTH    (RW),
    .REZ_MAX_WIDTH(RMW),
    .LOCK_COUNT   (LC)
  ) dut (
    .Clk            (clk),
    .Rst_n          (rst_n),
    .Sync_in        (sync_in),
    .Active_in      (active_in),
    .Meas_max       (meas_max),
    .Meas_activ     (meas_activ),
    .Meas_sync_width(meas_sync_width),
    .Meas_valid     (meas_valid),
    .Position       (position),
    .Locked         (locked),
    .Err            (err),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // one timing line: pre_idle low cycles, then len cycles starting with a sync edge
  typedef struct {
    int pre_idle;
    int p;
    int a;
    int s;
    int len;
    bit chk_pos;
    bit exp_valid;
    int exp_max;
    int exp_activ;
    int exp_sync;
    bit exp_locked;
    bit exp_err;
  } row_t;

  row_t          rows[NROWS];
  row_t          relock[4];
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            last_len = 0;

  function automatic row_t mk(int pre, int p, int a, int s, int len, bit pos,
                              bit v, int mx, int ac, int sy, bit lk, bit er);
    row_t r;
    r.pre_idle = pre; r.p = p; r.a = a; r.s = s; r.len = len; r.chk_pos = pos;
    r.exp_valid = v; r.exp_max = mx; r.exp_activ = ac; r.exp_sync = sy;
    r.exp_locked = lk; r.exp_err = er;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_meas_max"}, meas_max, 0);
    check({tag, "_meas_activ"}, meas_activ, 0);
    check({tag, "_meas_sync"}, meas_sync_width, 0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_position"}, position, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // scoreboard: every Meas_valid pops one expected capture
  always @(negedge clk) begin
    if (rst_n) begin
      if (meas_valid || err) check("valid_err_exclusive", meas_valid & err, 0);
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          check("meas_valid_unexpected", 1, 0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("cap_max", meas_max, e[EW-1 -: RMW]);
          check("cap_activ", meas_activ, e[RW+RW : RW+1]);
          check("cap_sync", meas_sync_width, e[RW:1]);
          check("cap_locked", locked, e[0]);
        end
      end
    end
  end

  // driver: one line, sampling outputs before driving each cycle
  task automatic run_row(input row_t r);
    for (int k = 0; k < r.pre_idle; k++) begin
      @(negedge clk);
      sync_in   = 1'b0;
      active_in = 1'b0;
    end
    for (int i = 0; i < r.len; i++) begin
      @(negedge clk);
      if (i == 1) check("meas_valid_at_edge", meas_valid, r.exp_valid);
      check("err", err, int'(r.exp_err && (i == 4096)));
      if (r.chk_pos) check("position", position, (i == 0) ? last_len - 1 : i - 1);
      if (r.exp_err && (i == 4097)) check_all_zero("timeout");
      if ((i == 0) && r.exp_valid)
        exp_q.push_back({RMW'(r.exp_max), RW'(r.exp_activ), RW'(r.exp_sync), r.exp_locked});
      sync_in   = (i < r.s);
      active_in = (i >= r.p - r.a) && (i < r.p);
    end
    last_len = r.len;
  endtask

  initial begin
    // reset lines 800/640/96 to lock
    rows[0]  = mk(0,  800,  640,   96,  800, 0, 0,    0,    0,   0, 0, 0);
    rows[1]  = mk(0,  800,  640,   96,  800, 0, 1,  800,  640,  96, 0, 0);
    rows[2]  = mk(0,  800,  640,   96,  800, 0, 1,  800,  640,  96, 0, 0);
    rows[3]  = mk(0,  800,  640,   96,  800, 0, 1,  800,  640,  96, 1, 0);
    rows[4]  = mk(0,  800,  640,   96,  800, 0, 1,  800,  640,  96, 1, 0);
    rows[5]  = mk(0,  800,  640,   96,  800, 1, 1,  800,  640,  96, 1, 0);
    // mode switch to 1184/1024
    rows[6]  = mk(0, 1184, 1024,  136, 1184, 0, 1,  800,  640,  96, 1, 0);
    rows[7]  = mk(0, 1184, 1024,  136, 1184, 0, 1, 1184, 1024, 136, 0, 0);
    rows[8]  = mk(0, 1184, 1024,  136, 1184, 0, 1, 1184, 1024, 136, 0, 0);
    rows[9]  = mk(0, 1184, 1024,  136, 1184, 0, 1, 1184, 1024, 136, 1, 0);
    rows[10] = mk(0, 1184, 1024,  136, 1184, 0, 1, 1184, 1024, 136, 1, 0);
    // last edge then Sync_in stays low -> timeout
    rows[11] = mk(0,  800,  640,   96, 5000, 0, 1, 1184, 1024, 136, 1, 1);
    rows[12] = mk(0,  800,  640,   96,  800, 0, 0,    0,    0,   0, 0, 0);
    rows[13] = mk(0,  800,  640,   96,  800, 0, 1,  800,  640,  96, 0, 0);
    rows[14] = mk(0,  800,  640,   96,  800, 0, 1,  800,  640,  96, 0, 0);
    rows[15] = mk(0,  800,  640,   96,  800, 0, 1,  800,  640,  96, 1, 0);
    // period 3000 with Active_in always high -> active saturates
    rows[16] = mk(0, 3000, 3000,   44, 3000, 0, 1,  800,  640,  96, 1, 0);
    rows[17] = mk(0, 3000, 3000,   44, 3000, 0, 1, 3000, 2047,  44, 0, 0);
    rows[18] = mk(0, 3000, 3000,   44, 3000, 0, 1, 3000, 2047,  44, 0, 0);
    // Sync_in held high -> single edge, then timeout
    rows[19] = mk(0, 5000,    0, 5000, 5000, 0, 1, 3000, 2047,  44, 1, 1);
    rows[20] = mk(2,  800,  640,   96,  800, 0, 0,    0,    0,   0, 0, 0);
    rows[21] = mk(0,  800,  640,   96,  800, 0, 1,  800,  640,  96, 0, 0);
    rows[22] = mk(0,  800,  640,   96,  800, 0, 1,  800,  640,  96, 0, 0);
    rows[23] = mk(0,  800,  640,   96,  300, 0, 1,  800,  640,  96, 1, 0);
    // after a mid-line reset: 1 + LOCK_COUNT edges to relock
    relock[0] = mk(0, 800, 640, 96, 800, 0, 0,   0,   0,  0, 0, 0);
    relock[1] = mk(0, 800, 640, 96, 800, 0, 1, 800, 640, 96, 0, 0);
    relock[2] = mk(0, 800, 640, 96, 800, 0, 1, 800, 640, 96, 0, 0);
    relock[3] = mk(0, 800, 640, 96, 800, 0, 1, 800, 640, 96, 1, 0);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < NROWS; n++) run_row(rows[n]);

    // asynchronous reset in the middle of a locked line
    @(negedge clk);
    check("locked_before_reset", locked, 1);
    #2 rst_n = 1'b0;
    sync_in   = 1'b0;
    active_in = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    check("queue_empty_at_reset", exp_q.size(), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("locked_after_release", locked, 0);

    for (int n = 0; n < 4; n++) run_row(relock[n]);

    repeat (5) @(negedge clk);
    check("locked_end", locked, 1);
    check("queue_empty_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
